// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, stream format
// constants and the word-address helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx * WORD_BYTES);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words; word_ready_o fires combinationally
// with the 4th byte so the completed word is {byte_i, lanes 2..0}.
module imem_loader_byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] asm_q, asm_d;

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (byte_vld_i) begin
      lane_d = lane_q + 2'd1;
      if (lane_q != 2'd3) asm_d[8*lane_q +: 8] = byte_i;
    end
    if (clr_i) lane_d = 2'd0;
  end

  // Only the lane counter is control; stale lanes are always overwritten before use.
  always_ff @(posedge clk_i) begin
    if (rst_i) lane_q <= 2'd0;
    else       lane_q <= lane_d;
    asm_q <= asm_d;
  end

  assign word_ready_o = byte_vld_i & (lane_q == 2'd3);
  assign word_o       = {byte_i, asm_q};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory
// and holds the core in reset until the image is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_loader_if.slave  bus,
  input  logic          reload_i,
  output logic          core_reset_o,
  output logic          load_done_o,
  output logic          load_error_o
);

  localparam int WIDX_W = $clog2(DEPTH_WORDS) + 1;

  state_e            state_q, state_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        accept, reload_ok, pk_vld, pk_ready;
  logic [31:0] pk_word, hdr_len;

  assign bus.rx_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign accept       = bus.rx_valid & bus.rx_ready;
  assign reload_ok    = reload_i & ((state_q == ST_RUN) || (state_q == ST_ERR));
  assign pk_vld       = accept & (state_q == ST_DATA);
  assign hdr_len      = {bus.rx_data, len_q[23:0]};

  imem_loader_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (reload_ok),
    .byte_vld_i   (pk_vld),
    .byte_i       (bus.rx_data),
    .word_ready_o (pk_ready),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    len_d        = len_q;
    widx_d       = widx_q;
    xor_d        = xor_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    err_d        = err_q;
    unique case (state_q)
      ST_HDR: if (accept) begin
        len_d[8*hdr_cnt_q +: 8] = bus.rx_data;
        xor_d     = xor_q ^ bus.rx_data;
        hdr_cnt_d = hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
          if (hdr_len > 32'(DEPTH_WORDS)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (hdr_len == 32'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: if (accept) begin
        xor_d = xor_q ^ bus.rx_data;
        if (pk_ready) begin
          we_d    = 1'b1;
          addr_d  = word_addr(BASE_ADDR, 32'(widx_q));
          wdata_d = pk_word;
          widx_d  = widx_q + 1'b1;
          if (32'(widx_q) + 32'd1 == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: if (accept) begin
        if (bus.rx_data == xor_q) begin
          state_d      = ST_RUN;
          done_d       = 1'b1;
          core_reset_d = 1'b0;
        end else begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
      ST_RUN, ST_ERR: if (reload_i) begin
        state_d      = ST_HDR;
        hdr_cnt_d    = 2'd0;
        len_d        = 32'd0;
        widx_d       = '0;
        xor_d        = 8'd0;
        addr_d       = BASE_ADDR;
        core_reset_d = 1'b1;
        done_d       = 1'b0;
        err_d        = 1'b0;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_HDR;
      hdr_cnt_q    <= 2'd0;
      len_q        <= 32'd0;
      widx_q       <= '0;
      xor_q        <= 8'd0;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= 32'd0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      len_q        <= len_d;
      widx_q       <= widx_d;
      xor_q        <= xor_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_reset_o   = core_reset_q;
  assign load_done_o    = done_q;
  assign load_error_o   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: byte streams are checked against a stream-format
// model that derives writes, latency and final status from the image bytes.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  logic rst, reload;
  logic core_reset, load_done, load_error;

  imem_loader_if ifc ();

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (ifc.slave),
    .reload_i     (reload),
    .core_reset_o (core_reset),
    .load_done_o  (load_done),
    .load_error_o (load_error)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  img[$];
  int          back2back = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (ifc.imem_we === 1'b1) begin
      wr_addr.push_back(ifc.imem_addr);
      wr_data.push_back(ifc.imem_wdata);
      if (prev_we === 1'b1) back2back++;
    end
    prev_we = ifc.imem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_capture();
    wr_addr.delete();
    wr_data.delete();
    back2back = 0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    t = 0;
    while (ifc.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rx_ready_timeout", 32'(ifc.rx_ready), 32'd1);
    else @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic build_img(input logic [31:0] len, input bit good);
    logic [7:0] x;
    int nbytes;
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back(len[8*i +: 8]);
    if (len > DEPTH) return;
    nbytes = 4 * int'(len);
    for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom_range(0, 255)));
    x = 8'd0;
    foreach (img[i]) x ^= img[i];
    img.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_done"},       32'(load_done),  32'd0);
    check({tag, "_error"},      32'(load_error), 32'd0);
    check({tag, "_ready"},      32'(ifc.rx_ready), 32'd1);
  endtask

  task automatic run_image(input string tag, input int maxgap, input int reload_at, input bit fresh);
    logic [31:0] len;
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [7:0]  x;
    bit          exp_done, exp_err;
    int          consumed, nw;
    len = {img[3], img[2], img[1], img[0]};
    if (len > DEPTH) begin
      exp_err = 1'b1; exp_done = 1'b0; consumed = 4; nw = 0;
    end else begin
      nw = int'(len);
      x = 8'd0;
      for (int i = 0; i < 4 + 4 * nw; i++) x ^= img[i];
      exp_done = (img[4 + 4 * nw] == x);
      exp_err  = !exp_done;
      consumed = 5 + 4 * nw;
      for (int i = 0; i < nw; i++) begin
        ea.push_back(BASE + 32'(4 * i));
        ed.push_back({img[7 + 4 * i], img[6 + 4 * i], img[5 + 4 * i], img[4 + 4 * i]});
      end
    end
    if (fresh) begin
      pulse_reload();
      check_idle({tag, "_reload"});
    end
    clear_capture();
    for (int i = 0; i < consumed; i++) begin
      if (i == reload_at) pulse_reload();
      send_byte(img[i], $urandom_range(0, maxgap));
      if (i >= 4 && i < 4 + 4 * nw && ((i - 4) % 4) == 3) begin
        check({tag, "_we_lat"},   32'(ifc.imem_we), 32'd1);
        check({tag, "_addr_lat"}, ifc.imem_addr, ea[(i - 4) / 4]);
      end
    end
    check({tag, "_done"},       32'(load_done),      32'(exp_done));
    check({tag, "_error"},      32'(load_error),     32'(exp_err));
    check({tag, "_core_reset"}, 32'(core_reset),     32'(!exp_done));
    check({tag, "_ready"},      32'(ifc.rx_ready),   32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(nw));
    for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
      check({tag, "_wr_addr"}, wr_addr[i], ea[i]);
      check({tag, "_wr_data"}, wr_data[i], ed[i]);
    end
    check({tag, "_we_one_cycle"}, 32'(back2back), 32'd0);
  endtask

  task automatic load_test1(input logic [7:0] trailer);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
            8'h13, 8'h81, 8'h10, 8'h00, 8'h43};
    img[12] = trailer;
  endtask

  initial begin
    rst          = 1'b1;
    reload       = 1'b0;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we",    32'(ifc.imem_we), 32'd0);
    check("rst_addr",  ifc.imem_addr,    BASE);
    check("rst_wdata", ifc.imem_wdata,   32'd0);
    check_idle("rst");
    rst = 1'b0;
    @(negedge clk);

    // Known program, good checksum
    load_test1(8'h43);
    run_image("t1", 0, -1, 1'b0);
    check("t1_w0", (wr_data.size() > 0) ? wr_data[0] : 32'hx, 32'h00500093);
    check("t1_w1", (wr_data.size() > 1) ? wr_data[1] : 32'hx, 32'h00108113);

    // Bad trailer; bytes offered afterwards must be ignored
    load_test1(8'h44);
    run_image("t2", 0, -1, 1'b1);
    clear_capture();
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = 8'h55;
    repeat (5) @(negedge clk);
    ifc.rx_valid = 1'b0;
    check("t2_ignored_wr", 32'(wr_addr.size()), 32'd0);
    check("t2_err_hold",   32'(load_error),     32'd1);

    // Oversize header, 300 words
    img = '{8'h2C, 8'h01, 8'h00, 8'h00};
    run_image("t3", 0, -1, 1'b1);

    // Test 1 with rx_valid gaps
    load_test1(8'h43);
    run_image("t4", 5, -1, 1'b1);

    // Reset mid-payload, then a clean load
    load_test1(8'h43);
    pulse_reload();
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_we",   32'(ifc.imem_we), 32'd0);
    check("t5_rst_addr", ifc.imem_addr,    BASE);
    check_idle("t5_rst");
    clear_capture();
    repeat (3) @(negedge clk);
    check("t5_no_stale_wr", 32'(wr_addr.size()), 32'd0);
    run_image("t5", 0, -1, 1'b0);

    // Empty image, then reload and full load
    img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_image("t6_empty", 0, -1, 1'b1);
    load_test1(8'h43);
    run_image("t6_again", 2, -1, 1'b1);

    // Boundaries: exactly DEPTH words accepted, DEPTH+1 rejected
    build_img(32'(DEPTH), 1'b1);
    run_image("max_len", 0, -1, 1'b1);
    build_img(32'(DEPTH + 1), 1'b1);
    run_image("over_len", 0, -1, 1'b1);

    // Random images with gaps and ignored mid-load reload pulses
    for (int n = 0; n < 20; n++) begin
      int ra;
      build_img(32'($urandom_range(0, 8)), ($urandom_range(0, 3) != 0));
      ra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, img.size() - 1)) : -1;
      run_image("rnd", 3, ra, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
